// File: rtl/ula_mul_ctrl.sv
`timescale 1ns/1ps
// ula_mul_ctrl
// Shift-and-add unsigned multiplier controller. It uses an external
// combinational ULA (adder) for the accumulate step. One bit of the
// multiplier is retired per RUN cycle, so a WIDTH-bit multiply takes
// WIDTH RUN cycles. These are followed by a single DONE cycle.
//
// Ports:
//   clk      - single clock, rising-edge active
//   rst      - synchronous active-high reset (priority over everything)
//   start    - begin a multiply; honoured only in IDLE
//   op_a     - multiplicand (unsigned, WIDTH bits)
//   op_b     - multiplier   (unsigned, WIDTH bits)
//   busy     - high while RUN
//   done     - one-cycle pulse; product is valid from this cycle on
//   product  - registered 2*WIDTH-bit result, held until next DONE/reset
//   ula_a    - ULA input_a (partial high word during RUN, else 0)
//   ula_b    - ULA input_b (multiplicand during RUN, else 0)
//   ula_sel  - ULA select, always add (2'b00)
//   ula_s    - ULA sum, combinational from ula_a/ula_b/ula_sel
//   ula_ovf  - ULA carry-out of the add
module ula_mul_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     ula_a,
  output logic [WIDTH-1:0]     ula_b,
  output logic [1:0]           ula_sel,
  input  logic [WIDTH-1:0]     ula_s,
  input  logic                 ula_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   step_acc;

  // The ULA only sees the datapath while RUN; elsewhere it is parked at zero.
  assign ula_a   = (state_q == RUN) ? hi_q    : '0;
  assign ula_b   = (state_q == RUN) ? mcand_q : '0;
  assign ula_sel = 2'b00;

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  always_comb begin
    // One shift-add step: the ULA carry becomes the new MSB of hi, so
    // the sum is effectively WIDTH+1 bits wide and no carry is lost.
    if (lo_q[0]) begin
      step_acc = {ula_ovf, ula_s, lo_q[WIDTH-1:1]};
    end else begin
      step_acc = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end

    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = op_a;
          hi_d    = '0;
          lo_d    = op_b;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        {hi_d, lo_d} = step_acc;
        if (count_q == LAST_STEP) begin
          // Final step: capture the post-step accumulator directly. Clear the
          // counter instead of letting it wrap.
          product_d = step_acc;
          count_d   = '0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          count_d   = count_q + CNT_W'(1);
          busy_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_ula_mul_ctrl.sv
`timescale 1ns/1ps
// Testbench for ula_mul_ctrl (WIDTH=4). It provides a behavioural ULA adder.
// Products are checked against plain a*b arithmetic. Handshake timing is
// checked against the expected cycle schedule of a multiply.
module tb_ula_mul_ctrl;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   ula_a;
  logic [W-1:0]   ula_b;
  logic [1:0]     ula_sel;
  logic [W-1:0]   ula_s;
  logic           ula_ovf;

  int checks;
  int errors;
  bit mon_en;
  logic [2*W-1:0] exp_prod;

  ula_mul_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ula_a   (ula_a),
    .ula_b   (ula_b),
    .ula_sel (ula_sel),
    .ula_s   (ula_s),
    .ula_ovf (ula_ovf)
  );

  // Behavioural ULA: select 00 adds with carry-out; other selects unused here.
  always_comb begin
    {ula_ovf, ula_s} = {1'b0, ula_a} + {1'b0, ula_b};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every-cycle checks of the ULA drive.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ula_sel !== 2'b00) begin
        errors++;
        $display("FAIL ula_sel: got %b expected 00", ula_sel);
      end
      if (busy === 1'b0) begin
        checks++;
        if (ula_a !== '0 || ula_b !== '0) begin
          errors++;
          $display("FAIL ula_idle_zero: got a=%h b=%h expected 0 0", ula_a, ula_b);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b product=%h expected 0 0 00",
               busy, done, product);
    end
    exp_prod = '0;
  endtask

  // One multiply with the expected schedule: busy for W cycles after the
  // accepting edge, done in cycle W+1, product = a*b. If poke is set,
  // start stays high (with operands 2,2) through RUN and DONE.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    logic [2*W-1:0] want;
    want = 8'(a) * 8'(b);
    @(posedge clk); #1;
    start = 1'b1; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = poke;
    op_a = poke ? 4'd2 : 4'($urandom);
    op_b = poke ? 4'd2 : 4'($urandom);
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== exp_prod) begin
        errors++;
        $display("FAIL run_cycle%0d (%0d*%0d): got busy=%b done=%b product=%h expected 1 0 %h",
                 c, a, b, busy, done, product, exp_prod);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || product !== want) begin
      errors++;
      $display("FAIL done_cycle (%0d*%0d): got busy=%b done=%b product=%h expected 0 1 %h",
               a, b, busy, done, product, want);
    end
    exp_prod = want;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < (poke ? 3 : 1); c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== exp_prod) begin
        errors++;
        $display("FAIL after_done (%0d*%0d): got busy=%b done=%b product=%h expected 0 0 %h",
                 a, b, busy, done, product, exp_prod);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    run_mul(4'd3, 4'd1, 1'b0);
  endtask

  task automatic test_all_ones();
    run_mul(4'd15, 4'd15, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_mul(4'd0, 4'd9, 1'b0);
    run_mul(4'd10, 4'd6, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_mul(4'd5, 4'd5, 1'b1);
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    start = 1'b1; op_a = 4'd7; op_b = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_run1: got busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_run2: got busy=%b expected 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b product=%h expected 0 0 00",
               busy, done, product);
    end
    exp_prod = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got busy=%b done=%b expected 0 0", busy, done);
      end
    end
    run_mul(4'd7, 4'd3, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_mul(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0; exp_prod = '0;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    test_reset();
    test_basic();
    test_all_ones();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_random();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_mul_ctrl.md
ULA_MUL_CTRL -- requirements
Module: ula_mul_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal 2..16).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin one multiply, sampled on the rising edge.
REQ-005 The block SHALL have port op_a  input  WIDTH  multiplicand, unsigned.
REQ-006 The block SHALL have port op_b  input  WIDTH  multiplier, unsigned.
REQ-007 The block SHALL have port busy  output  1  high while a multiply is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking product valid.
REQ-009 The block SHALL have port product  output  2*WIDTH  registered unsigned result.
REQ-010 The block SHALL have port ula_a  output  WIDTH  ULA input_a drive.
REQ-011 The block SHALL have port ula_b  output  WIDTH  ULA input_b drive.
REQ-012 The block SHALL have port ula_sel  output  2  ULA select drive; 2'b00 = add.
REQ-013 The block SHALL have port ula_s  input  WIDTH  ULA output_s, combinational from ula_a/ula_b/ula_sel.
REQ-014 The block SHALL have port ula_ovf  input  1  ULA ovf; carry-out of the add.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 at an edge SHALL load mcand<=op_a, hi<=0, lo<=op_b, count<=0, and move to RUN; op_a/op_b are not sampled again.
REQ-017 start SHALL be ignored in RUN and DONE (no reload, no restart, no queuing).
REQ-018 In RUN, the block SHALL drive ula_a=hi, ula_b=mcand, ula_sel=2'b00.
REQ-019 Each RUN edge SHALL perform one step: if lo[0]=1, {hi,lo} <= {ula_ovf, ula_s, lo[WIDTH-1:1]}; else {hi,lo} <= {1'b0, hi, lo[WIDTH-1:1]}; then count<=count+1.
REQ-020 On the RUN edge where count reaches WIDTH-1, the block SHALL write product <= the post-step {hi,lo} and move to DONE.
REQ-021 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE unconditionally.
REQ-022 done SHALL be asserted in the cycle after edge E0+WIDTH, where E0 is the start-accepting edge (latency WIDTH+1 edges to the done cycle).
REQ-023 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-024 product SHALL hold its value from the DONE write until the next DONE write or reset; it SHALL NOT change at start.
REQ-025 Outside RUN, ula_a and ula_b SHALL be 0 and ula_sel SHALL be 2'b00.
REQ-026 The carry from ula_ovf SHALL never be dropped; the product SHALL equal op_a*op_b exactly for all operand values, including all-ones.
REQ-027 The step counter SHALL be $clog2(WIDTH) bits wide, and it SHALL not wrap within a multiply.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, busy=0, done=0, product=0, hi=lo=mcand=count=0, and SHALL have priority over start and all FSM activity.
REQ-029 rst asserted mid-RUN SHALL abort the multiply with no done pulse; the first start after rst deasserts SHALL begin a fresh multiply.

Verification
REQ-030 Bench, WIDTH=4: rst, then start with op_a=3, op_b=1 -> busy=1 for 4 cycles; done=1 for one cycle in the 5th cycle after the start edge; product=8'h03.
REQ-031 Bench: op_a=15, op_b=15 -> product=8'hE1 (225), exercising ula_ovf carry into the high bit.
REQ-032 Bench: op_a=0, op_b=9 -> product=8'h00, then op_a=10, op_b=6 -> product=8'h3C; done pulses once per multiply.
REQ-033 Bench: start with op_a=5, op_b=5, then re-pulse start with op_a=2, op_b=2 during RUN and DONE -> ignored; product=8'h19; no second done pulse.
REQ-034 Bench: rst raised at the 2nd RUN cycle -> next cycle busy=0, done=0, product=0; no done pulse follows; start with op_a=7, op_b=3 -> product=8'h15.
REQ-035 Bench, every cycle: ula_sel=2'b00; ula_a=ula_b=0 whenever busy=0; pass/fail counts printed at the end.
